// File: rtl/bootcopy_pkg.sv
// Shared types and constants for the bootcopy ROM-to-RAM boot copy engine.
package bootcopy_pkg;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    COPY  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam int          ROM_DEPTH         = 256;
  localparam int          ROM_LATENCY       = 1;
  localparam int          IDX_W             = $clog2(ROM_DEPTH) + 1;
  localparam logic [15:0] DEFAULT_DEST_BASE = 16'hFF00;

  // RAM destination for a given copy index; wraps past 16'hFFFF.
  function automatic logic [15:0] dest_addr(input logic [15:0] base,
                                            input logic [IDX_W-1:0] idx);
    return base + {{(16-IDX_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/bootcopy_csum.sv
// 8-bit modular accumulator over copied bytes; flags whether the sum including
// the byte currently on din equals the expected image checksum.
module bootcopy_csum
  import bootcopy_pkg::*;
#(
  parameter logic [7:0] EXPECT_SUM = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic       match
);

  logic [7:0] sum;
  logic [7:0] sum_next;

  assign sum_next = sum + din;
  assign match    = (sum_next == EXPECT_SUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum_next;
    end
  end

endmodule

// File: rtl/bootcopy.sv
// Boot copy engine: streams the bootstrap ROM into RAM, then releases the CPU.
// Build macro BOOTCOPY_CSUM_EN adds an image checksum check, ERROR state and csum_err.
module bootcopy
  import bootcopy_pkg::*;
#(
  parameter logic [15:0] DEST_BASE  = DEFAULT_DEST_BASE,
  parameter int          LENGTH     = ROM_DEPTH
`ifdef BOOTCOPY_CSUM_EN
  ,
  parameter logic [7:0]  EXPECT_SUM = 8'h00
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_dbw,
  output logic        ram_we,
  input  logic        ram_busy,
  input  logic        reload,
  output logic        cpu_rst_n,
  output logic        done
`ifdef BOOTCOPY_CSUM_EN
  ,
  output logic        csum_err
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             cpu_rst_n_nxt;

`ifdef BOOTCOPY_CSUM_EN
  logic csum_match;

  bootcopy_csum #(
    .EXPECT_SUM(EXPECT_SUM)
  ) u_csum (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == PRIME),
    .en   (ram_we & ~ram_busy),
    .din  (ram_dbw),
    .match(csum_match)
  );

  assign csum_err = (state == ERROR);
`endif

  assign ram_addr = dest_addr(DEST_BASE, idx);
  assign ram_dbw  = rom_data;
  assign done     = (state == DONE);

  // NOTE: every output of this block gets a default before the case so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ram_we    = 1'b0;
    rom_addr  = 8'd0;
    case (state)
      PRIME: state_nxt = COPY;
      COPY: begin
        ram_we = 1'b1;
        // Look one byte ahead on accept so the registered ROM data lines up
        // with the next write; under a stall the address holds.
        rom_addr = ram_busy ? idx[7:0] : idx[7:0] + 8'd1;
        if (!ram_busy) begin
          if (idx == LAST_IDX) begin
            idx_nxt = '0;
`ifdef BOOTCOPY_CSUM_EN
            state_nxt = csum_match ? DONE : ERROR;
`else
            state_nxt = DONE;
`endif
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      DONE: if (reload) state_nxt = PRIME;
`ifdef BOOTCOPY_CSUM_EN
      ERROR: if (reload) state_nxt = PRIME;
`endif
      default: state_nxt = PRIME;
    endcase
    cpu_rst_n_nxt = (state_nxt == DONE);
  end

  // NOTE: state is updated with non-blocking assignments so all registers see
  // the pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PRIME;
      idx       <= '0;
      cpu_rst_n <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cpu_rst_n <= cpu_rst_n_nxt;
    end
  end

endmodule

// File: tb/tb_bootcopy.sv
// Self-checking bench for bootcopy: table-driven copy runs, random RAM stalls,
// reload and mid-copy reset sequences, and checksum runs when BOOTCOPY_CSUM_EN is set.
module tb_bootcopy;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]       rst_v;
  logic                ram_busy;
  logic                reload;
  logic [NI-1:0][7:0]  rom_q;
  wire  [NI-1:0][7:0]  rom_addr;
  wire  [NI-1:0][15:0] ram_addr;
  wire  [NI-1:0][7:0]  ram_dbw;
  wire  [NI-1:0]       ram_we;
  wire  [NI-1:0]       cpu_rst_n;
  wire  [NI-1:0]       done;
  wire  [NI-1:0]       csum_err;

  logic [7:0]  rom_mem   [NI][256];
  logic [15:0] dest_of   [NI];
  int          len_of    [NI];
  logic [7:0]  sum_of    [NI];
  bit          busy_pat  [4096];

  int n_tests = 0;
  int n_fail  = 0;

  bootcopy #(.DEST_BASE(16'hFF00), .LENGTH(256)
`ifdef BOOTCOPY_CSUM_EN
    , .EXPECT_SUM(8'h80)
`endif
  ) dut0 (
    .clk(clk), .rst_n(rst_v[0]), .rom_addr(rom_addr[0]), .rom_data(rom_q[0]),
    .ram_addr(ram_addr[0]), .ram_dbw(ram_dbw[0]), .ram_we(ram_we[0]), .ram_busy(ram_busy),
    .reload(reload), .cpu_rst_n(cpu_rst_n[0]), .done(done[0])
`ifdef BOOTCOPY_CSUM_EN
    , .csum_err(csum_err[0])
`endif
  );

  bootcopy #(.DEST_BASE(16'hFFF0), .LENGTH(32)
`ifdef BOOTCOPY_CSUM_EN
    , .EXPECT_SUM(8'hF0)
`endif
  ) dut1 (
    .clk(clk), .rst_n(rst_v[1]), .rom_addr(rom_addr[1]), .rom_data(rom_q[1]),
    .ram_addr(ram_addr[1]), .ram_dbw(ram_dbw[1]), .ram_we(ram_we[1]), .ram_busy(ram_busy),
    .reload(reload), .cpu_rst_n(cpu_rst_n[1]), .done(done[1])
`ifdef BOOTCOPY_CSUM_EN
    , .csum_err(csum_err[1])
`endif
  );

`ifdef BOOTCOPY_CSUM_EN
  bootcopy #(.DEST_BASE(16'hFF00), .LENGTH(256), .EXPECT_SUM(8'h00)) dut2 (
    .clk(clk), .rst_n(rst_v[2]), .rom_addr(rom_addr[2]), .rom_data(rom_q[2]),
    .ram_addr(ram_addr[2]), .ram_dbw(ram_dbw[2]), .ram_we(ram_we[2]), .ram_busy(ram_busy),
    .reload(reload), .cpu_rst_n(cpu_rst_n[2]), .done(done[2]), .csum_err(csum_err[2])
  );

  bootcopy #(.DEST_BASE(16'hFF00), .LENGTH(256), .EXPECT_SUM(8'h01)) dut3 (
    .clk(clk), .rst_n(rst_v[3]), .rom_addr(rom_addr[3]), .rom_data(rom_q[3]),
    .ram_addr(ram_addr[3]), .ram_dbw(ram_dbw[3]), .ram_we(ram_we[3]), .ram_busy(ram_busy),
    .reload(reload), .cpu_rst_n(cpu_rst_n[3]), .done(done[3]), .csum_err(csum_err[3])
  );
`else
  assign csum_err = '0;
  assign rom_addr[3:2]  = '0;
  assign ram_addr[3:2]  = '0;
  assign ram_dbw[3:2]   = '0;
  assign ram_we[3:2]    = '0;
  assign cpu_rst_n[3:2] = '0;
  assign done[3:2]      = '0;
`endif

  // ROM models: one-cycle registered read.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) rom_q[k] <= rom_mem[k][rom_addr[k]];
  end

  // Write log and edge counter per instance; edge 1 is the first edge after release.
  int          edge_cnt [NI];
  int          wr_cnt   [NI];
  int          rise_edge[NI];
  logic [15:0] wr_addr  [NI][1024];
  logic [7:0]  wr_data  [NI][1024];
  int          wr_edge  [NI][1024];

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_v[k]) begin
        edge_cnt[k] <= 0;
        wr_cnt[k]   <= 0;
      end else begin
        edge_cnt[k] <= edge_cnt[k] + 1;
        if (ram_we[k] === 1'b1 && !ram_busy && wr_cnt[k] < 1024) begin
          wr_addr[k][wr_cnt[k]] <= ram_addr[k];
          wr_data[k][wr_cnt[k]] <= ram_dbw[k];
          wr_edge[k][wr_cnt[k]] <= edge_cnt[k] + 1;
          wr_cnt[k]             <= wr_cnt[k] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_v[k]) rise_edge[k] <= 0;
      else if (cpu_rst_n[k] === 1'b1 && rise_edge[k] == 0) rise_edge[k] <= edge_cnt[k];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full copy on instance k with ram_busy taken from busy_pat[edge].
  task automatic run(input int k, output int got_done, output logic [15:0] got_last);
    int          len;
    logic [15:0] dest;
    int          exp_edge[$];
    int          m, exp_done, cyc_err, seq_err, n, wc;
    logic [7:0]  s;
    bit          exp_err;
    len  = len_of[k];
    dest = dest_of[k];
    // Reference: each unstalled edge from edge 2 on writes the next byte.
    m = 0; exp_done = 0;
    for (int e = 2; e < 4096 && m < len; e++) begin
      if (!busy_pat[e]) begin
        exp_edge.push_back(e);
        m++;
        if (m == len) exp_done = e;
      end
    end
    s = 8'h00;
    for (int i = 0; i < len; i++) s = s + rom_mem[k][i];
    exp_err = 1'b0;
`ifdef BOOTCOPY_CSUM_EN
    exp_err = (s != sum_of[k]);
`endif
    @(negedge clk);
    rst_v[k] = 1'b0; ram_busy = 1'b0; reload = 1'b0;
    repeat (2) @(negedge clk);
    check($sformatf("rst_cpu_rst_n[%0d]", k), 32'(cpu_rst_n[k]), 0);
    check($sformatf("rst_done[%0d]", k), 32'(done[k]), 0);
    check($sformatf("rst_ram_we[%0d]", k), 32'(ram_we[k]), 0);
    check($sformatf("rst_rom_addr[%0d]", k), 32'(rom_addr[k]), 0);
    rst_v[k] = 1'b1;
    ram_busy = busy_pat[1];
    cyc_err = 0; n = 1;
    while (n < 4000 && rise_edge[k] == 0 && csum_err[k] !== 1'b1) begin
      @(negedge clk);
      n++;
      ram_busy = busy_pat[n];
      #1;
      if (ram_we[k] === 1'b1) begin
        wc = wr_cnt[k];
        if (ram_addr[k] !== 16'(dest + 16'(wc)) || ram_dbw[k] !== rom_mem[k][wc[7:0]] ||
            rom_addr[k] !== (ram_busy ? wc[7:0] : 8'(wc + 1)))
          cyc_err++;
      end
    end
    ram_busy = 1'b0;
    repeat (8) @(negedge clk);
    check($sformatf("cycle_outputs[%0d]", k), cyc_err, 0);
    check($sformatf("write_count[%0d]", k), wr_cnt[k], len);
    seq_err = 0;
    for (int i = 0; i < len; i++) begin
      if (wr_addr[k][i] !== 16'(dest + 16'(i)) || wr_data[k][i] !== rom_mem[k][i] ||
          wr_edge[k][i] != exp_edge[i])
        seq_err++;
    end
    check($sformatf("write_seq[%0d]", k), seq_err, 0);
    if (exp_err) begin
      check($sformatf("csum_err[%0d]", k), 32'(csum_err[k]), 1);
      check($sformatf("err_cpu_rst_n[%0d]", k), 32'(cpu_rst_n[k]), 0);
      check($sformatf("err_done[%0d]", k), 32'(done[k]), 0);
    end else begin
      check($sformatf("done_edge[%0d]", k), rise_edge[k], exp_done);
      check($sformatf("done[%0d]", k), 32'(done[k]), 1);
      check($sformatf("cpu_rst_n[%0d]", k), 32'(cpu_rst_n[k]), 1);
      check($sformatf("idle_ram_we[%0d]", k), 32'(ram_we[k]), 0);
    end
    got_done = rise_edge[k];
    got_last = wr_addr[k][len-1];
  endtask

  typedef struct {
    int          k;
    int          stall_idx;
    int          stall_len;
    int          exp_done;
    logic [15:0] exp_last;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[4];
    int          d, n, base;
    logic [15:0] la;
    bit          found;

    vecs[0] = '{0, -1, 0, 257, 16'hFFFF};
    vecs[1] = '{0, 10, 3, 260, 16'hFFFF};
    vecs[2] = '{1, -1, 0, 33,  16'h000F};
    vecs[3] = '{1, 15, 2, 35,  16'h000F};

    for (int i = 0; i < 256; i++) begin
      rom_mem[0][i] = 8'(i) ^ 8'h5A;
      rom_mem[1][i] = 8'(i) ^ 8'h5A;
      rom_mem[2][i] = 8'h01;
      rom_mem[3][i] = 8'h01;
    end
    dest_of = '{16'hFF00, 16'hFFF0, 16'hFF00, 16'hFF00};
    len_of  = '{256, 32, 256, 256};
    sum_of  = '{8'h80, 8'hF0, 8'h00, 8'h01};
    rst_v = '0; ram_busy = 1'b0; reload = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[v]) begin
      for (int e = 0; e < 4096; e++) busy_pat[e] = 1'b0;
      for (int j = 0; j < vecs[v].stall_len; j++) busy_pat[vecs[v].stall_idx + 2 + j] = 1'b1;
      run(vecs[v].k, d, la);
      check($sformatf("tbl_done_edge[%0d]", v), d, vecs[v].exp_done);
      check($sformatf("tbl_last_addr[%0d]", v), 32'(la), 32'(vecs[v].exp_last));
    end

    // Reload from DONE restarts; a reload mid-COPY is ignored.
    base = wr_cnt[0];
    @(negedge clk); reload = 1'b1;
    @(negedge clk); reload = 1'b0;
    check("reload_cpu_rst_n", 32'(cpu_rst_n[0]), 0);
    check("reload_done", 32'(done[0]), 0);
    n = 0;
    while (cpu_rst_n[0] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
      reload = (n == 50);
    end
    reload = 1'b0;
    check("reload_edges", n, 257);
    repeat (4) @(negedge clk);
    check("reload_writes", wr_cnt[0] - base, 256);
    check("reload_no_queue", 32'(done[0]), 1);

    // Asynchronous reset at idx 100, then restart from idx 0.
    @(negedge clk); rst_v[0] = 1'b0;
    repeat (2) @(negedge clk); rst_v[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (ram_we[0] === 1'b1 && ram_addr[0] == 16'hFF64) found = 1'b1;
    end
    check("midrst_reach_idx100", 32'(found), 1);
    #2 rst_v[0] = 1'b0;
    #1;
    check("midrst_cpu_rst_n", 32'(cpu_rst_n[0]), 0);
    check("midrst_done", 32'(done[0]), 0);
    check("midrst_ram_we", 32'(ram_we[0]), 0);
    check("midrst_rom_addr", 32'(rom_addr[0]), 0);
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_first_addr", 32'(wr_addr[0][0]), 32'h0000FF00);
    check("midrst_first_data", 32'(wr_data[0][0]), 32'h5A);
    check("midrst_write_count", wr_cnt[0], 2);

    // Random RAM stalls.
    for (int k = 0; k < 2; k++) begin
      for (int e = 0; e < 4096; e++) busy_pat[e] = ($urandom_range(0, 3) == 0);
      run(k, d, la);
    end

`ifdef BOOTCOPY_CSUM_EN
    for (int e = 0; e < 4096; e++) busy_pat[e] = 1'b0;
    run(2, d, la);
    run(3, d, la);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
